// File: rtl/carfield_pwr_seq_pkg.sv
// Shared types and constants for the Carfield domain power sequencer.
// Domain indices follow the Carfield clock/reset domain map.
package carfield_pwr_seq_pkg;

  localparam int unsigned NumDomainsDefault    = 6;
  localparam int unsigned RstCyclesDefault     = 16;
  localparam int unsigned IsoCyclesDefault     = 4;
  localparam int unsigned TimeoutCyclesDefault = 1024;

  localparam int unsigned DomL2      = 0;
  localparam int unsigned DomSpatz   = 1;
  localparam int unsigned DomPulp    = 2;
  localparam int unsigned DomSecured = 3;
  localparam int unsigned DomSafety  = 4;
  localparam int unsigned DomPeriph  = 5;

  typedef enum logic [2:0] {
    IDLE,
    CFG_DIV,
    CLK_ON,
    RST_WAIT,
    ISO_WAIT,
    ISO_ON,
    ISO_HOLD,
    RST_HOLD
  } pwr_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/carfield_pwr_seq_rr_arb.sv
// Round-robin arbiter: combinational pick of the first pending index at or
// after the pointer (wrapping); the pointer moves past the grant on advance_i.
module carfield_pwr_seq_rr_arb #(
  parameter  int unsigned NumReq = 6,
  localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] pending_i,
  input  logic              advance_i,
  output logic              grant_valid_o,
  output logic [IdxW-1:0]   grant_idx_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] cand;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    cand          = ptr_q;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!grant_valid_o && pending_i[cand]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = cand;
      end
      cand = (cand == IdxW'(NumReq - 1)) ? '0 : cand + 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && grant_valid_o) begin
      ptr_d = (grant_idx_o == IdxW'(NumReq - 1)) ? '0 : grant_idx_o + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/carfield_domain_pwr_seq.sv
// Shared power-up/power-down sequencer for the Carfield clock/reset domains.
// Optional divider handshake timeout: define CARFIELD_PWR_SEQ_TIMEOUT_EN.
module carfield_domain_pwr_seq
  import carfield_pwr_seq_pkg::*;
#(
  parameter  int unsigned NumDomains    = NumDomainsDefault,
  parameter  int unsigned DivWidth      = 8,
  parameter  int unsigned RstCycles     = RstCyclesDefault,
  parameter  int unsigned IsoCycles     = IsoCyclesDefault,
  parameter  int unsigned TimeoutCycles = TimeoutCyclesDefault,
  localparam int unsigned IdxW          = (NumDomains > 1) ? $clog2(NumDomains) : 1,
  localparam int unsigned CntW          = $clog2(max3(RstCycles, IsoCycles, TimeoutCycles) + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumDomains-1:0]          dom_en_req_i,
  input  logic [NumDomains*DivWidth-1:0] div_value_i,
  output logic                           div_cfg_valid_o,
  input  logic                           div_cfg_ready_i,
  output logic [IdxW-1:0]                div_cfg_idx_o,
  output logic [DivWidth-1:0]            div_cfg_value_o,
  output logic [NumDomains-1:0]          clk_en_o,
  output logic [NumDomains-1:0]          rst_no,
  output logic [NumDomains-1:0]          iso_o,
  output logic [NumDomains-1:0]          dom_active_o,
  output logic                           busy_o,
  output logic [NumDomains-1:0]          err_o
);

  pwr_state_e              state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [DivWidth-1:0]     value_q, value_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [NumDomains-1:0]   clk_en_q, clk_en_d;
  logic [NumDomains-1:0]   rst_n_q, rst_n_d;
  logic [NumDomains-1:0]   iso_q, iso_d;
  logic [NumDomains-1:0]   active_q, active_d;
  logic [NumDomains-1:0]   err_q;
  logic [NumDomains-1:0]   pending;
  logic                    grant_valid;
  logic [IdxW-1:0]         grant_idx;
  logic                    advance;

`ifdef CARFIELD_PWR_SEQ_TIMEOUT_EN
  logic [NumDomains-1:0]   err_d;
`endif

  // Timed-out domains drop out of arbitration until the next reset.
  assign pending = (dom_en_req_i ^ active_q) & ~err_q;

  carfield_pwr_seq_rr_arb #(
    .NumReq (NumDomains)
  ) u_rr_arb (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .pending_i     (pending),
    .advance_i     (advance),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    value_d  = value_q;
    cnt_d    = cnt_q;
    clk_en_d = clk_en_q;
    rst_n_d  = rst_n_q;
    iso_d    = iso_q;
    active_d = active_q;
    advance  = 1'b0;
`ifdef CARFIELD_PWR_SEQ_TIMEOUT_EN
    err_d    = err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          advance = 1'b1;
          idx_d   = grant_idx;
          if (dom_en_req_i[grant_idx]) begin
            // The divider value is captured once here and held through the handshake.
            for (int unsigned d = 0; d < NumDomains; d++) begin
              if (grant_idx == IdxW'(d)) value_d = div_value_i[d*DivWidth +: DivWidth];
            end
            cnt_d   = '0;
            state_d = CFG_DIV;
          end else begin
            state_d = ISO_ON;
          end
        end
      end

      CFG_DIV: begin
        if (div_cfg_ready_i) begin
          state_d = CLK_ON;
        end
`ifdef CARFIELD_PWR_SEQ_TIMEOUT_EN
        else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
          err_d[idx_q] = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      CLK_ON: begin
        clk_en_d[idx_q] = 1'b1;
        cnt_d           = CntW'(RstCycles - 1);
        state_d         = RST_WAIT;
      end

      RST_WAIT: begin
        if (cnt_q == '0) begin
          rst_n_d[idx_q] = 1'b1;
          cnt_d          = CntW'(IsoCycles - 1);
          state_d        = ISO_WAIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ISO_WAIT: begin
        if (cnt_q == '0) begin
          iso_d[idx_q]    = 1'b0;
          active_d[idx_q] = 1'b1;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ISO_ON: begin
        iso_d[idx_q]    = 1'b1;
        active_d[idx_q] = 1'b0;
        cnt_d           = CntW'(IsoCycles - 1);
        state_d         = ISO_HOLD;
      end

      ISO_HOLD: begin
        if (cnt_q == '0) begin
          rst_n_d[idx_q] = 1'b0;
          cnt_d          = CntW'(RstCycles - 1);
          state_d        = RST_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RST_HOLD: begin
        if (cnt_q == '0) begin
          clk_en_d[idx_q] = 1'b0;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      value_q  <= '0;
      cnt_q    <= '0;
      clk_en_q <= '0;
      rst_n_q  <= '0;
      iso_q    <= '1;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      value_q  <= value_d;
      cnt_q    <= cnt_d;
      clk_en_q <= clk_en_d;
      rst_n_q  <= rst_n_d;
      iso_q    <= iso_d;
      active_q <= active_d;
    end
  end

`ifdef CARFIELD_PWR_SEQ_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= '0;
    else         err_q <= err_d;
  end
`else
  assign err_q = '0;
`endif

  assign div_cfg_valid_o = (state_q == CFG_DIV);
  assign div_cfg_idx_o   = idx_q;
  assign div_cfg_value_o = value_q;
  assign clk_en_o        = clk_en_q;
  assign rst_no          = rst_n_q;
  assign iso_o           = iso_q;
  assign dom_active_o    = active_q;
  assign busy_o          = (state_q != IDLE);
  assign err_o           = err_q;

endmodule

// File: tb/tb_carfield_domain_pwr_seq.sv
// Scoreboard bench for carfield_domain_pwr_seq: stimulus queues expected
// output events with cycle gaps, a negedge monitor pops and compares them.
module tb_carfield_domain_pwr_seq;

  localparam int N   = 6;
  localparam int W   = 8;
  localparam int RST = 16;
  localparam int ISO = 4;
  localparam int TMO = 1024;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic [N-1:0]   dom_en_req_i;
  logic [N*W-1:0] div_value_i;
  logic           div_cfg_valid_o;
  logic           div_cfg_ready_i;
  logic [2:0]     div_cfg_idx_o;
  logic [W-1:0]   div_cfg_value_o;
  logic [N-1:0]   clk_en_o, rst_no, iso_o, dom_active_o, err_o;
  logic           busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  carfield_domain_pwr_seq #(
    .NumDomains    (N),
    .DivWidth      (W),
    .RstCycles     (RST),
    .IsoCycles     (ISO),
    .TimeoutCycles (TMO)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .dom_en_req_i    (dom_en_req_i),
    .div_value_i     (div_value_i),
    .div_cfg_valid_o (div_cfg_valid_o),
    .div_cfg_ready_i (div_cfg_ready_i),
    .div_cfg_idx_o   (div_cfg_idx_o),
    .div_cfg_value_o (div_cfg_value_o),
    .clk_en_o        (clk_en_o),
    .rst_no          (rst_no),
    .iso_o           (iso_o),
    .dom_active_o    (dom_active_o),
    .busy_o          (busy_o),
    .err_o           (err_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef enum int {EV_HS, EV_CLK, EV_RST, EV_ISO, EV_ACT, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       dom;
    int       data;
    int       gap;   // cycles since previous event, -1 = not checked
  } ev_t;

  ev_t exp_q[$];
  int  cyc      = 0;
  int  last_cyc = 0;
  logic [N-1:0] p_clk, p_rst, p_iso, p_act, p_err;

  function automatic void push(input ev_kind_e k, input int d, input int v, input int g);
    ev_t e;
    e.kind = k; e.dom = d; e.data = v; e.gap = g;
    exp_q.push_back(e);
  endfunction

  function automatic void push_up(input int d, input int v, input int hs_gap);
    push(EV_HS,  d, v, hs_gap);
    push(EV_CLK, d, 1, 2);
    push(EV_RST, d, 1, RST);
    push(EV_ISO, d, 0, ISO);
    push(EV_ACT, d, 1, 0);
  endfunction

  function automatic void push_down(input int d);
    push(EV_ISO, d, 1, -1);
    push(EV_ACT, d, 0, 0);
    push(EV_RST, d, 0, ISO);
    push(EV_CLK, d, 0, RST);
  endfunction

  task automatic observe(input ev_kind_e k, input int d, input int v);
    ev_t e;
    int  gap;
    gap      = cyc - last_cyc;
    last_cyc = cyc;
    if (exp_q.size() == 0) begin
      check($sformatf("unexpected_event_k%0d_d%0d_v%0d", k, d, v), exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("ev_kind_d%0d", e.dom), k, e.kind);
      check($sformatf("ev_dom_k%0d", e.kind), d, e.dom);
      check($sformatf("ev_data_k%0d_d%0d", e.kind, e.dom), v, e.data);
      if (e.gap >= 0) check($sformatf("ev_gap_k%0d_d%0d", e.kind, e.dom), gap, e.gap);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      cyc++;
      if (rst_ni === 1'b1) begin
        if (div_cfg_valid_o && div_cfg_ready_i)
          observe(EV_HS, int'(div_cfg_idx_o), int'(div_cfg_value_o));
        for (int d = 0; d < N; d++) if (clk_en_o[d] !== p_clk[d])     observe(EV_CLK, d, int'(clk_en_o[d]));
        for (int d = 0; d < N; d++) if (rst_no[d] !== p_rst[d])       observe(EV_RST, d, int'(rst_no[d]));
        for (int d = 0; d < N; d++) if (iso_o[d] !== p_iso[d])        observe(EV_ISO, d, int'(iso_o[d]));
        for (int d = 0; d < N; d++) if (dom_active_o[d] !== p_act[d]) observe(EV_ACT, d, int'(dom_active_o[d]));
        for (int d = 0; d < N; d++) if (err_o[d] !== p_err[d])        observe(EV_ERR, d, int'(err_o[d]));
      end
      p_clk = clk_en_o;
      p_rst = rst_no;
      p_iso = iso_o;
      p_act = dom_active_o;
      p_err = err_o;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic drain(input int budget, input string name);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      tick();
      i++;
    end
    check({name, "_events_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic set_val(input int d, input logic [W-1:0] v);
    div_value_i[d*W +: W] = v;
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_clk_en"},     clk_en_o,        '0);
    check({pfx, "_rst_n"},      rst_no,          '0);
    check({pfx, "_iso"},        iso_o,           6'b111111);
    check({pfx, "_active"},     dom_active_o,    '0);
    check({pfx, "_cfg_valid"},  div_cfg_valid_o, 0);
    check({pfx, "_cfg_idx"},    div_cfg_idx_o,   0);
    check({pfx, "_cfg_value"},  div_cfg_value_o, 0);
    check({pfx, "_busy"},       busy_o,          0);
    check({pfx, "_err"},        err_o,           '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni          = 1'b0;
    dom_en_req_i    = '0;
    div_cfg_ready_i = 1'b1;
    div_value_i     = '0;
    set_val(0, 8'h10);
    set_val(1, 8'h21);
    set_val(2, 8'h04);
    set_val(3, 8'h33);
    set_val(4, 8'h44);
    set_val(5, 8'h55);
    tick(3);
    check_reset("reset");
    rst_ni = 1'b1;
    tick(2);

    // Pointer 0: 0, 3, 5 in order; 1 raised while 3 runs comes after 5.
    push_up(0, 8'h10, -1);
    push_up(3, 8'h33, 1);
    push_up(5, 8'h55, 1);
    push_up(1, 8'h21, 1);
    dom_en_req_i = 6'b101001;
    begin
      int i = 0;
      while (!dom_active_o[0] && i < 100) begin
        tick();
        i++;
      end
    end
    check("rr_dom0_active", dom_active_o[0], 1);
    tick(5);
    dom_en_req_i[1] = 1'b1;
    drain(200, "rr_order");

    // Domain 2 power-up with value 0x04, ready tied high.
    push_up(2, 8'h04, -1);
    dom_en_req_i[2] = 1'b1;
    drain(100, "dom2_up");

    // Domain 4 with ready held low for 50 cycles; input value changes after entry.
    div_cfg_ready_i = 1'b0;
    dom_en_req_i[4] = 1'b1;
    begin
      int i = 0;
      while (!div_cfg_valid_o && i < 10) begin
        tick();
        i++;
      end
    end
    check("stall_valid_seen", div_cfg_valid_o, 1);
    set_val(4, 8'h99);
    push_up(4, 8'h44, -1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      check("stall_valid", div_cfg_valid_o, 1);
      check("stall_idx",   div_cfg_idx_o,   4);
      check("stall_value", div_cfg_value_o, 8'h44);
    end
    @(posedge clk_i);
    #1;
    div_cfg_ready_i = 1'b1;
    drain(100, "dom4_up");

    // Domain 4 power-down.
    push_down(4);
    dom_en_req_i[4] = 1'b0;
    drain(100, "dom4_down");
    tick();
    check("dom4_down_busy", busy_o, 0);
    check("dom4_down_active", dom_active_o, 6'b101111);

    // Domain 1 off, then on; reset in the middle of its RST_WAIT.
    push_down(1);
    dom_en_req_i[1] = 1'b0;
    drain(100, "dom1_down");
    push(EV_HS,  1, 8'h21, -1);
    push(EV_CLK, 1, 1, 2);
    dom_en_req_i[1] = 1'b1;
    drain(50, "dom1_pre_rst");
    tick(3);
    check("mid_rst_busy_before", busy_o, 1);
    rst_ni       = 1'b0;
    dom_en_req_i = 6'b000010;
    #1;
    check_reset("mid_rst");
    tick(2);
    push_up(1, 8'h21, -1);
    rst_ni = 1'b1;
    drain(100, "dom1_reseq");

`ifdef CARFIELD_PWR_SEQ_TIMEOUT_EN
    // Domain 0 times out; domain 3 still sequences and 0 is never regranted.
    push(EV_ERR, 0, 1, -1);
    div_cfg_ready_i = 1'b0;
    dom_en_req_i[0] = 1'b1;
    begin
      int n = 0;
      for (int i = 0; i < 2000; i++) begin
        tick();
        if (div_cfg_valid_o) n++;
        else if (n > 0) break;
      end
      check("tmo_valid_cycles", n, TMO);
    end
    drain(5, "tmo_err");
    check("tmo_err_flag", err_o, 6'b000001);
    push_up(3, 8'h33, -1);
    div_cfg_ready_i = 1'b1;
    dom_en_req_i[3] = 1'b1;
    drain(100, "tmo_other_dom");
    tick(50);
    check("tmo_busy_idle", busy_o, 0);
    check("tmo_active", dom_active_o, 6'b001010);
    check("tmo_err_sticky", err_o, 6'b000001);
`else
    check("err_tied_low", err_o, '0);
`endif

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/carfield_domain_pwr_seq.md
Name: carfield_domain_pwr_seq

Overview:
Shared power-up/power-down sequencer for the Carfield clock/reset domains (L2, Spatz, PULP, secured, safety, periph); one sequencer serves all domains.
- Arbitrates per-domain enable/disable requests round-robin.
- Programs the domain's clock-divider value over a valid/ready config port.
- Orders clock ungating, reset release and isolation removal, and the reverse on power-down.
- Sits between the SoC control registers and the per-domain clock dividers, gates and reset synchronisers.

Parameters:
NumDomains, 6, number of sequenced domains (equals the package domain count).
DivWidth, 8, clock divider value width.
RstCycles, 16, cycles the domain clock runs with reset asserted before reset release (>=1).
IsoCycles, 4, cycles between reset release and isolation removal, and between isolation on and reset assert (>=1).
TimeoutCycles, 1024, divider handshake timeout (only with optional feature).

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
dom_en_req_i  in  NumDomains  requested on/off state per domain (level)
div_value_i  in  NumDomains*DivWidth  divider value per domain, slice d = [d*DivWidth +: DivWidth]
div_cfg_valid_o  out  1  divider config request
div_cfg_ready_i  in  1  divider accepted config
div_cfg_idx_o  out  $clog2(NumDomains)  target domain of config
div_cfg_value_o  out  DivWidth  divider value
clk_en_o  out  NumDomains  per-domain clock gate enable
rst_no  out  NumDomains  per-domain active-low reset
iso_o  out  NumDomains  per-domain isolation enable (1 = isolated)
dom_active_o  out  NumDomains  domain fully on
busy_o  out  1  sequencer not IDLE
err_o  out  NumDomains  sticky handshake timeout flag

Behaviour:
- Interface: one clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values:
  - clk_en_o = 0, rst_no = 0, iso_o = all 1, dom_active_o = 0.
  - div_cfg_valid_o = 0, div_cfg_idx_o = 0, div_cfg_value_o = 0.
  - busy_o = 0, err_o = 0; FSM in IDLE; arbiter pointer = 0.
- Pending[d] = dom_en_req_i[d] != dom_active_o[d].
- IDLE:
  - If any pending, the round-robin grant picks the lowest index >= pointer, wrapping.
  - Register the granted index and the requested direction; the pointer moves to grant+1 mod NumDomains.
  - Power-up goes to CFG_DIV; power-down goes to ISO_ON.
- Power-up path:
  - CFG_DIV: div_cfg_valid_o = 1; idx and value are held stable until the handshake (valid & ready), then go to CLK_ON. Valid never drops without ready.
  - CLK_ON: clk_en_o[d] = 1, load counter RstCycles-1, go to RST_WAIT.
  - RST_WAIT: decrement; at 0 set rst_no[d] = 1, load IsoCycles-1, go to ISO_WAIT.
  - ISO_WAIT: decrement; at 0 clear iso_o[d], set dom_active_o[d], go to IDLE.
- Power-down path:
  - ISO_ON: iso_o[d] = 1, clear dom_active_o[d], load IsoCycles-1, go to ISO_HOLD.
  - ISO_HOLD: at 0 rst_no[d] = 0, load RstCycles-1, go to RST_HOLD.
  - RST_HOLD: at 0 clk_en_o[d] = 0, go to IDLE.
- Latency: power-up = 1 (grant) + handshake + 1 + RstCycles + IsoCycles cycles; power-down = 1 + IsoCycles + RstCycles + 1.
- A request change for the in-flight domain mid-sequence is ignored until IDLE; the domain is then re-evaluated as pending.
- One domain is sequenced at a time; other domains' outputs stay stable.
- div_value_i is sampled only at the CFG_DIV entry.
- Async reset mid-sequence returns all outputs to reset values immediately.
- Counter width is $clog2(max(RstCycles, IsoCycles, TimeoutCycles)+1).

Optional Feature:
CARFIELD_PWR_SEQ_TIMEOUT_EN:
- Defined:
  - A counter runs in CFG_DIV. If TimeoutCycles elapse without ready, drop valid, set err_o[d] sticky and return to IDLE with the domain left off.
  - A domain with err_o[d] set is excluded from arbitration until reset.
- Undefined: no timeout, CFG_DIV waits indefinitely, err_o tied 0.

Decomposition:
- Package carfield_pwr_seq_pkg holds:
  - the FSM state enum (IDLE, CFG_DIV, CLK_ON, RST_WAIT, ISO_WAIT, ISO_ON, ISO_HOLD, RST_HOLD);
  - default RstCycles/IsoCycles/TimeoutCycles constants;
  - the per-domain index localparams taken from the domain index map.
- One sub-module, carfield_pwr_seq_rr_arb: combinational round-robin pick plus a registered pointer, with pending vector in and grant index/valid out.

Test Plan:
- Reset, then raise dom_en_req_i[2] with div value 0x04 and ready tied 1:
  - idx = 2 / value = 0x04 handshake;
  - clk_en_o[2] rises;
  - rst_no[2] rises 16 cycles later;
  - iso_o[2] falls 4 cycles after that;
  - dom_active_o[2] = 1.
- Request domains 0, 3 and 5 simultaneously with pointer 0: sequenced in order 0, 3, 5; a later request for 1 comes after 5 (wrap).
- Hold div_cfg_ready_i low for 50 cycles: valid and idx/value stay stable for all 50 cycles; sequencing resumes the cycle after ready.
- Active domain 4, drop its request: iso_o[4] = 1, rst_no[4] falls 4 cycles later, clk_en_o[4] falls 16 cycles after that, busy_o returns to 0.
- Assert rst_ni low during RST_WAIT of domain 1: all outputs return to reset values the same cycle; after release the still-high request re-sequences domain 1 from CFG_DIV.
- With the macro defined, ready held low for 1024 cycles: err_o[0] set, valid drops, domain 0 is never regranted, and other domains still sequence normally.
